cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have parameter TAG_W, default 10, meaning cache tag width in bits.
REQ-002 The block SHALL have parameter IDX_W, default 6, meaning cache set-index width in bits.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-005 The block SHALL have ports rd_en, wr_en  input  1 each  memory-stage read / write request.
REQ-006 The block SHALL have ports addr  input  32  byte address, and wdata  input  32  store data.
REQ-007 The block SHALL have ports rdata  output  32  load data, and ready  output  1  request complete; pipeline freezes while 0.
REQ-008 The block SHALL have ports cache_r_en, cache_w_en  output  1 each  cache fill strobe / cache invalidate strobe.
REQ-009 The block SHALL have ports cache_tag  output  TAG_W, cache_index  output  IDX_W, cache_wdata  output  64  fill line.
REQ-010 The block SHALL have ports cache_rdata  input  64  hit line, and cache_hit  input  1  combinational hit.
REQ-011 The block SHALL have ports sram_rd_en, sram_wr_en  output  1 each; sram_addr  output  32; sram_wdata  output  32.
REQ-012 The block SHALL have ports sram_rdata  input  64  two-word line, and sram_ready  input  1  SRAM access done.

Function
REQ-013 Address split SHALL be: word select addr[2], index addr[IDX_W+2:3], tag addr[TAG_W+IDX_W+2:IDX_W+3]; addr[1:0] ignored.
REQ-014 FSM states SHALL be IDLE, MISS, WRITE; encoding free.
REQ-015 With no request in IDLE, ready SHALL be 1 and all strobes 0.
REQ-016 In IDLE, cache_tag/cache_index SHALL be driven from live addr; in MISS/WRITE, from addr_q latched at state entry.
REQ-017 IDLE, rd_en=1, wr_en=0, cache_hit=1: ready=1 same cycle, rdata = addr[2] ? cache_rdata[63:32] : cache_rdata[31:0], state stays IDLE.
REQ-018 IDLE, rd_en=1, wr_en=0, cache_hit=0: ready=0, latch addr into addr_q, next state MISS.
REQ-019 In MISS: sram_rd_en=1, sram_addr={addr_q[31:3],3'b000}, ready=0 until sram_ready=1.
REQ-020 MISS with sram_ready=1: cache_r_en=1 for exactly that cycle, cache_wdata=sram_rdata, ready=1, rdata = word of sram_rdata selected by addr_q[2], next IDLE.
REQ-021 IDLE, wr_en=1: cache_w_en=1 for exactly that cycle (invalidate matching way), ready=0, latch addr/wdata, next WRITE.
REQ-022 In WRITE: sram_wr_en=1, sram_addr=addr_q, sram_wdata=wdata_q, ready=0 until sram_ready=1; on that cycle ready=1, next IDLE.
REQ-023 rd_en=1 and wr_en=1 together SHALL be treated as a write.
REQ-024 cache_r_en and cache_w_en SHALL never be 1 in the same cycle; sram_rd_en and sram_wr_en SHALL never be 1 together.
REQ-025 Changes on rd_en, wr_en, addr, wdata while in MISS/WRITE SHALL be ignored until return to IDLE.
REQ-026 A request present in IDLE on the cycle after completion SHALL be accepted normally (back-to-back, no bubble beyond REQ-018/021).
REQ-027 sram_ready while in IDLE SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, addr_q=0, wdata_q=0, all strobes 0, independent of clk.
REQ-029 Reset mid-MISS or mid-WRITE SHALL abandon the access with no cache_r_en pulse; after release, ready=1 when idle.
REQ-030 Resulting output values during reset SHALL be ready=1, rdata=0, sram_addr=0, sram_wdata=0, cache_wdata=0.

Verification
REQ-031 Read hit: addr=0x0000_0404, cache_hit=1, cache_rdata=0xAAAA_BBBB_CCCC_DDDD -> ready=1 same cycle, rdata=0xAAAA_BBBB, no SRAM strobe.
REQ-032 Read miss: addr=0x0000_0200, cache_hit=0, sram_ready after 4 MISS cycles with sram_rdata=0x1111_2222_3333_4444 -> sram_addr=0x200 held, one cache_r_en pulse, rdata=0x3333_4444, ready=1 on that cycle only.
REQ-033 Write: addr=0x0000_0010, wdata=0xDEAD_BEEF -> cache_w_en one cycle, tag=0, index=2; sram_wr_en with sram_wdata=0xDEAD_BEEF until sram_ready; then IDLE.
REQ-034 rd_en=wr_en=1 on addr=0x8 -> write path taken, sram_rd_en never asserted.
REQ-035 rst=0 asserted 2 cycles into MISS -> strobes drop asynchronously, no cache_r_en; after rst=1 a hit read completes in 1 cycle.
REQ-036 Back-to-back miss then hit at different indices -> second request accepted the cycle after first ready=1, correct rdata both.

Source files
------------

// File: rtl/cache_controller.sv
// ============================================================================
// Module : cache_controller
// Brief  : Blocking direct-mapped cache controller for a memory pipeline stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_controller #(
    parameter int TAG_W = 10,
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               cache_r_en,
    output logic               cache_w_en,
    output logic [TAG_W-1:0]   cache_tag,
    output logic [IDX_W-1:0]   cache_index,
    output logic [63:0]        cache_wdata,
    input  logic [63:0]        cache_rdata,
    input  logic               cache_hit,
    output logic               sram_rd_en,
    output logic               sram_wr_en,
    output logic [31:0]        sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [63:0]        sram_rdata,
    input  logic               sram_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Writes win over reads when both are requested.
    logic w_wr_req;
    logic w_rd_req;
    assign w_wr_req = wr_en;
    assign w_rd_req = rd_en && !wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_wr_req) begin
                        state_q <= WRITE;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                    end else if (w_rd_req && !cache_hit) begin
                        state_q <= MISS;
                        addr_q  <= addr;
                    end
                end
                MISS:    if (sram_ready) state_q <= IDLE;
                WRITE:   if (sram_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [31:0] w_tag_src;
    assign w_tag_src = (state_q == IDLE) ? addr : addr_q;

    // Outputs are qualified by rst so they drop asynchronously while held in reset.
    always_comb begin
        ready       = 1'b1;
        rdata       = 32'd0;
        cache_r_en  = 1'b0;
        cache_w_en  = 1'b0;
        cache_wdata = 64'd0;
        sram_rd_en  = 1'b0;
        sram_wr_en  = 1'b0;
        sram_addr   = 32'd0;
        sram_wdata  = 32'd0;
        cache_tag   = w_tag_src[TAG_W+IDX_W+2:IDX_W+3];
        cache_index = w_tag_src[IDX_W+2:3];
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (w_wr_req) begin
                        cache_w_en = 1'b1;
                        ready      = 1'b0;
                    end else if (w_rd_req) begin
                        ready = cache_hit;
                        if (cache_hit)
                            rdata = addr[2] ? cache_rdata[63:32] : cache_rdata[31:0];
                    end
                end
                MISS: begin
                    sram_rd_en  = 1'b1;
                    sram_addr   = {addr_q[31:3], 3'b000};
                    cache_wdata = sram_rdata;
                    ready       = sram_ready;
                    cache_r_en  = sram_ready;
                    if (sram_ready)
                        rdata = addr_q[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                end
                WRITE: begin
                    sram_wr_en = 1'b1;
                    sram_addr  = addr_q;
                    sram_wdata = wdata_q;
                    ready      = sram_ready;
                end
                default: ready = 1'b1;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
// Module : tb_cache_controller
// Brief  : Directed self-checking bench for cache_controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready, cache_r_en, cache_w_en;
    logic [9:0]  cache_tag;
    logic [5:0]  cache_index;
    logic [63:0] cache_wdata, cache_rdata, sram_rdata;
    logic        cache_hit, sram_rd_en, sram_wr_en, sram_ready;
    logic [31:0] sram_addr, sram_wdata;

    int total = 0;
    int bad   = 0;

    cache_controller #(.TAG_W(10), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .cache_r_en(cache_r_en), .cache_w_en(cache_w_en),
        .cache_tag(cache_tag), .cache_index(cache_index),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h404; wdata = 32'h0;
        cache_hit = 1'b1; cache_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        sram_rdata = 64'h0; sram_ready = 1'b0;
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobes", {cache_r_en, cache_w_en, sram_rd_en, sram_wr_en}, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_cache_wdata", cache_wdata, 0);
        rst = 1'b1; rd_en = 1'b0; cache_hit = 1'b0;
        tick();
        #1;
        chk("idle_ready", ready, 1);
        chk("idle_strobes", {cache_r_en, cache_w_en, sram_rd_en, sram_wr_en}, 0);

        // Read hit, upper word
        rd_en = 1'b1; cache_hit = 1'b1; addr = 32'h404;
        #1;
        chk("hit_ready", ready, 1);
        chk("hit_rdata_hi", rdata, 32'hAAAA_BBBB);
        chk("hit_tag", cache_tag, 10'd2);
        chk("hit_index", cache_index, 6'd0);
        chk("hit_no_sram", {sram_rd_en, sram_wr_en, cache_r_en}, 0);
        tick();
        addr = 32'h400;
        #1;
        chk("hit_rdata_lo", rdata, 32'hCCCC_DDDD);

        // Read miss with 4 MISS cycles
        addr = 32'h200; cache_hit = 1'b0;
        #1;
        chk("miss_idle_ready", ready, 0);
        tick();
        rd_en = 1'b0; wr_en = 1'b1; addr = 32'hFFF8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("miss_wait_rd_en", sram_rd_en, 1);
            chk("miss_wait_addr", sram_addr, 32'h200);
            chk("miss_wait_ready", ready, 0);
            chk("miss_wait_idx", {cache_tag, cache_index}, {10'd1, 6'd0});
            chk("miss_wait_no_fill", {cache_r_en, cache_w_en, sram_wr_en}, 0);
            tick();
        end
        sram_ready = 1'b1; sram_rdata = 64'h1111_2222_3333_4444;
        #1;
        chk("miss_fill", cache_r_en, 1);
        chk("miss_ready", ready, 1);
        chk("miss_rdata", rdata, 32'h3333_4444);
        chk("miss_cache_wdata", cache_wdata, 64'h1111_2222_3333_4444);
        chk("miss_addr_last", sram_addr, 32'h200);
        wr_en = 1'b0;
        tick();
        #1;
        chk("idle_sram_ready_ignored", {ready, cache_r_en, sram_rd_en}, 3'b100);
        sram_ready = 1'b0;

        // Write
        wr_en = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_inval", cache_w_en, 1);
        chk("wr_idle_ready", ready, 0);
        chk("wr_tag_idx", {cache_tag, cache_index}, {10'd0, 6'd2});
        chk("wr_idle_sram", {sram_wr_en, cache_r_en}, 0);
        tick();
        wr_en = 1'b0; addr = 32'h5555; wdata = 32'h1234_5678;
        #1;
        chk("wr_sram_en", {sram_wr_en, sram_rd_en, cache_w_en}, 3'b100);
        chk("wr_sram_addr", sram_addr, 32'h10);
        chk("wr_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        chk("wr_wait_ready", ready, 0);
        tick();
        sram_ready = 1'b1;
        #1;
        chk("wr_done_ready", ready, 1);
        tick();
        sram_ready = 1'b0;
        #1;
        chk("wr_back_idle", {ready, sram_wr_en}, 2'b10);

        // Simultaneous read and write -> write
        rd_en = 1'b1; wr_en = 1'b1; addr = 32'h8; cache_hit = 1'b1;
        #1;
        chk("rw_inval", {cache_w_en, ready, sram_rd_en}, 3'b100);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        chk("rw_write_path", {sram_wr_en, sram_rd_en}, 2'b10);
        chk("rw_addr", sram_addr, 32'h8);
        sram_ready = 1'b1;
        #1;
        chk("rw_done", {ready, sram_rd_en}, 2'b10);
        tick();
        sram_ready = 1'b0;

        // Reset two cycles into a miss
        rd_en = 1'b1; cache_hit = 1'b0; addr = 32'h300;
        tick();
        rd_en = 1'b0;
        tick();
        #1;
        chk("rst_miss_active", sram_rd_en, 1);
        sram_ready = 1'b1; sram_rdata = 64'hFFFF_0000_FFFF_0000;
        rst = 1'b0;
        #1;
        chk("rst_async_strobes", {cache_r_en, cache_w_en, sram_rd_en, sram_wr_en}, 0);
        chk("rst_async_ready", ready, 1);
        chk("rst_async_addr", sram_addr, 0);
        rst = 1'b1; sram_ready = 1'b0;
        tick();
        #1;
        chk("post_rst_idle", {ready, sram_rd_en}, 2'b10);
        rd_en = 1'b1; cache_hit = 1'b1; addr = 32'h404;
        cache_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("post_rst_hit", {ready, rdata}, {1'b1, 32'h0123_4567});

        // Back-to-back miss then hit at a different index
        addr = 32'h208; cache_hit = 1'b0;
        tick();
        rd_en = 1'b0;
        sram_ready = 1'b1; sram_rdata = 64'h5555_6666_7777_8888;
        #1;
        chk("b2b_miss", {ready, cache_r_en, rdata}, {2'b11, 32'h7777_8888});
        tick();
        sram_ready = 1'b0;
        rd_en = 1'b1; cache_hit = 1'b1; addr = 32'h14;
        cache_rdata = 64'h9999_AAAA_BBBB_CCCC;
        #1;
        chk("b2b_hit", {ready, rdata}, {1'b1, 32'h9999_AAAA});
        chk("b2b_hit_idx", cache_index, 6'd2);
        chk("b2b_no_sram", {sram_rd_en, cache_r_en}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
